ecc_sed_encoder: RTL and testbench
==================================

// Module: ecc_sed_encoder
// PURPOSE
//  Single-error-detect (SED) encoder: appends one parity bit to a data word.
//  Sits on the write path ahead of storage or a link; the matching checker lives downstream.
//  Valid/ready streaming on both sides, registered output, 2-entry skid so the input ready is registered.
// PARAMETERS
//  DATA_WIDTH   48  data word width in bits (>=1)
//  ODD_PARITY   0   0: even parity (codeword popcount even); 1: odd parity
// PORTS
//  clk           in   1             clock, rising edge
//  rst           in   1             asynchronous, active-low reset
//  data          in   DATA_WIDTH    data word to encode
//  data_valid    in   1             data is valid this cycle
//  data_ready    out  1             encoder can accept data (registered)
//  enc_codeword  out  DATA_WIDTH+1  {parity, data}; parity is the MSB
//  enc_valid     out  1             enc_codeword is valid
//  enc_ready     in   1             downstream accepts codeword
// BEHAVIOUR
//  - Clocking: one clock; rst is asynchronous and active-low.
//  - Parity: p = ^data ^ ODD_PARITY. Codeword = {p, data[DATA_WIDTH-1:0]}. Data bits pass unmodified.
//  - Input transfer: occurs when data_valid && data_ready. Output transfer: occurs when enc_valid && enc_ready.
//  - Storage: main output register (OUT) plus one skid register (SKID), each with its own valid bit.
//  - Latency: an accepted word appears on enc_codeword the next cycle, with enc_valid=1, if OUT is empty or draining.
//  - Throughput: 1 word/cycle sustained while enc_ready=1.
//  - data_ready = !skid_valid (registered). It drops the cycle after a word lands in SKID.
//  - Next-state rules, evaluated per clock:
//     * OUT empty, or OUT transferring: OUT <= SKID if skid_valid, else the input word if accepted.
//       skid_valid clears when SKID moves.
//     * OUT full and stalled (enc_ready=0) with an accepted input: the word goes to SKID; skid_valid=1.
//     * Simultaneous accept and transfer with SKID full cannot occur, because data_ready=0.
//  - Stability: enc_codeword and enc_valid hold steady while enc_valid && !enc_ready (AXI-style).
//  - Data values: no illegal data values exist. All-zero and all-one words encode normally.
//  - Reset (asserted at any time, including mid-transfer):
//     * enc_valid=0, enc_codeword=0, skid_valid=0, data_ready=0.
//     * data_ready rises 1 cycle after rst deasserts.
//     * In-flight words are dropped.
//  - Inputs are ignored when data_valid=0. data is don't-care when data_valid=0.
// STRUCTURE
//  - Package ecc_pkg: localparam DEFAULT_DATA_WIDTH=48; function automatic sed_parity(data, odd).
//  - Sub-module ecc_parity_tree #(WIDTH, ODD): combinational XOR reduction, out = ^in ^ ODD.
//    Written as a balanced tree for wide words.
//  - Top level: ecc_parity_tree on the input plus the OUT/SKID control (valid bits, ready register).
// TESTING
//  - Reset: hold rst=0 with data_valid=1.
//    -> enc_valid=0, enc_codeword=0, data_ready=0; data_ready=1 one cycle after release.
//  - Single word, enc_ready=1: data=48'h0123_4567_89AB.
//    -> next cycle enc_valid=1, enc_codeword=49'h0_0123_4567_89AB (popcount 20, p=0).
//  - Odd popcount: data=48'h1 -> 49'h1_0000_0000_0001.
//    With ODD_PARITY=1 the same data gives 49'h0_0000_0000_0001.
//  - Boundaries: data=48'h0 -> 49'h0; data=48'hFFFF_FFFF_FFFF -> 49'h0_FFFF_FFFF_FFFF.
//  - Stream of 10 back-to-back words with enc_ready=1.
//    -> 10 codewords in order, on consecutive cycles, with no gaps.
//  - Backpressure: enc_ready=0 during a 3-word burst.
//    -> OUT holds word0, SKID takes word1, data_ready=0, word2 stalls.
//    -> after enc_ready=1, words 0,1,2 emerge in order with none lost or duplicated.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared constants and a reference parity helper for the SED encoder family.
package ecc_pkg;

  localparam int DEFAULT_DATA_WIDTH = 48;

  function automatic logic sed_parity(input logic [DEFAULT_DATA_WIDTH-1:0] data,
                                      input logic                          odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/ecc_parity_tree.sv
// Combinational parity of a word, reduced as a balanced XOR tree, optionally inverted for odd parity.
module ecc_parity_tree
  import ecc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit ODD   = 1'b0
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_o
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int PAD    = 1 << LEVELS;

  logic [PAD-1:0] tree;

  // Zero-pad to a power of two, then fold pairs in place: each level halves the live width.
  // NOTE: every signal written in always_comb gets a full default first, so no path can infer a latch.
  always_comb begin
    tree = '0;
    tree[WIDTH-1:0] = data_i;
    for (int w = PAD / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        tree[i] = tree[2*i] ^ tree[2*i+1];
      end
    end
  end

  assign parity_o = tree[0] ^ ODD;

endmodule

// File: rtl/ecc_sed_encoder.sv
// Single-error-detect encoder: {parity, data} behind a registered output stage with a one-deep skid buffer.
module ecc_sed_encoder
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic [DATA_WIDTH:0]   enc_codeword,
  output logic                  enc_valid,
  input  logic                  enc_ready
);

  logic                in_parity;
  logic [DATA_WIDTH:0] in_cw;
  logic                in_fire;

  logic [DATA_WIDTH:0] out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_WIDTH:0] skid_q, skid_d;
  logic                skid_valid_q, skid_valid_d;
  logic                ready_q, ready_d;

  ecc_parity_tree #(
    .WIDTH (DATA_WIDTH),
    .ODD   (ODD_PARITY)
  ) u_parity (
    .data_i   (data),
    .parity_o (in_parity)
  );

  assign in_cw   = {in_parity, data};
  assign in_fire = data_valid && ready_q;

  // SKID only fills while OUT is stalled; it always drains into OUT before new input is taken.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || enc_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) begin
          out_d = in_cw;
        end
      end
    end else if (in_fire) begin
      skid_d       = in_cw;
      skid_valid_d = 1'b1;
    end
    ready_d = !skid_valid_d;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // Payload registers are reset too, because the codeword output must read zero during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign data_ready   = ready_q;
  assign enc_codeword = out_q;
  assign enc_valid    = out_valid_q;

endmodule

// File: tb/tb_ecc_sed_encoder.sv
// Self-checking bench for ecc_sed_encoder: vector table, streaming, backpressure and reset sequences.
module tb_ecc_sed_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] data;
  logic        data_valid;
  logic        enc_ready;
  logic        data_ready, data_ready_odd;
  logic [48:0] enc_codeword, enc_codeword_odd;
  logic        enc_valid, enc_valid_odd;

  always #5 clk = ~clk;

  ecc_sed_encoder #(.DATA_WIDTH(48), .ODD_PARITY(1'b0)) dut (
    .clk          (clk),
    .rst          (rst),
    .data         (data),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .enc_codeword (enc_codeword),
    .enc_valid    (enc_valid),
    .enc_ready    (enc_ready)
  );

  ecc_sed_encoder #(.DATA_WIDTH(48), .ODD_PARITY(1'b1)) dut_odd (
    .clk          (clk),
    .rst          (rst),
    .data         (data),
    .data_valid   (data_valid),
    .data_ready   (data_ready_odd),
    .enc_codeword (enc_codeword_odd),
    .enc_valid    (enc_valid_odd),
    .enc_ready    (enc_ready)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [48:0] model_cw(input logic [47:0] d, input bit odd);
    logic p;
    p = (($countones(d) % 2) == 1) ^ odd;
    return {p, d};
  endfunction

  // Scoreboard: expected codewords pushed on input transfer, popped on output transfer.
  logic [48:0] sb_even[$];
  logic [48:0] sb_odd[$];
  logic        prev_stall;
  logic [48:0] prev_cw;

  always @(negedge clk) begin
    if (!rst) begin
      sb_even.delete();
      sb_odd.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", 64'(enc_valid), 64'd1);
        check("stall_hold_cw", 64'(enc_codeword), 64'(prev_cw));
      end
      check("odd_inst_valid_match", 64'(enc_valid_odd), 64'(enc_valid));
      if (enc_valid && enc_ready) begin
        if (sb_even.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_unexpected_output: got %h, expected no output (t=%0t)", enc_codeword, $time);
        end else begin
          check("sb_even_cw", 64'(enc_codeword), 64'(sb_even.pop_front()));
          check("sb_odd_cw", 64'(enc_codeword_odd), 64'(sb_odd.pop_front()));
        end
      end
      if (data_valid && data_ready) begin
        sb_even.push_back(model_cw(data, 1'b0));
        sb_odd.push_back(model_cw(data, 1'b1));
      end
      prev_stall = enc_valid && !enc_ready;
      prev_cw    = enc_codeword;
    end
  end

  typedef struct {
    logic [47:0] data;
    logic [48:0] exp_even;
    logic [48:0] exp_odd;
  } vec_t;

  vec_t        vecs[7];
  logic [47:0] stream_w[10];
  logic [47:0] bp_w[3];

  initial begin
    vecs[0] = '{48'h0123_4567_89AB, 49'h0_0123_4567_89AB, 49'h1_0123_4567_89AB};
    vecs[1] = '{48'h0000_0000_0001, 49'h1_0000_0000_0001, 49'h0_0000_0000_0001};
    vecs[2] = '{48'h0000_0000_0000, 49'h0_0000_0000_0000, 49'h1_0000_0000_0000};
    vecs[3] = '{48'hFFFF_FFFF_FFFF, 49'h0_FFFF_FFFF_FFFF, 49'h1_FFFF_FFFF_FFFF};
    vecs[4] = '{48'h8000_0000_0000, 49'h1_8000_0000_0000, 49'h0_8000_0000_0000};
    vecs[5] = '{48'hA5A5_A5A5_A5A5, 49'h0_A5A5_A5A5_A5A5, 49'h1_A5A5_A5A5_A5A5};
    vecs[6] = '{48'h0000_0000_0007, 49'h1_0000_0000_0007, 49'h0_0000_0000_0007};
    for (int i = 0; i < 10; i++) stream_w[i] = {16'($urandom), 32'($urandom)};
    bp_w[0] = 48'h1111_2222_3333;
    bp_w[1] = 48'h4444_5555_6667;
    bp_w[2] = 48'h8888_9999_AAAB;

    // Reset held with data_valid asserted.
    rst        = 1'b0;
    data_valid = 1'b1;
    data       = 48'hDEAD_BEEF_0001;
    enc_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_enc_valid", 64'(enc_valid), 64'd0);
    check("rst_enc_codeword", 64'(enc_codeword), 64'd0);
    check("rst_data_ready", 64'(data_ready), 64'd0);
    check("rst_odd_codeword", 64'(enc_codeword_odd), 64'd0);
    data_valid = 1'b0;
    #1 rst = 1'b1;
    #1 check("ready_low_right_after_release", 64'(data_ready), 64'd0);
    @(negedge clk);
    check("ready_high_one_cycle_after_release", 64'(data_ready), 64'd1);

    // Table-driven single words, enc_ready held high.
    for (int i = 0; i < 7; i++) begin
      @(posedge clk) #1;
      data       = vecs[i].data;
      data_valid = 1'b1;
      @(posedge clk) #1;
      data_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 64'(enc_valid), 64'd1);
      check($sformatf("vec%0d_even_cw", i), 64'(enc_codeword), 64'(vecs[i].exp_even));
      check($sformatf("vec%0d_odd_cw", i), 64'(enc_codeword_odd), 64'(vecs[i].exp_odd));
    end

    // Ten back-to-back words: outputs must arrive on consecutive cycles.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk) #1;
      data       = stream_w[i];
      data_valid = 1'b1;
      @(negedge clk);
      check("stream_ready", 64'(data_ready), 64'd1);
      if (i > 0) check($sformatf("stream_no_gap_%0d", i - 1), 64'(enc_valid), 64'd1);
    end
    @(posedge clk) #1;
    data_valid = 1'b0;
    @(negedge clk);
    check("stream_last_valid", 64'(enc_valid), 64'd1);
    @(negedge clk);
    check("stream_idle_after", 64'(enc_valid), 64'd0);
    check("stream_sb_drained", 64'(sb_even.size()), 64'd0);

    // Backpressure during a 3-word burst.
    @(posedge clk) #1;
    enc_ready  = 1'b0;
    data       = bp_w[0];
    data_valid = 1'b1;
    @(posedge clk) #1;
    data = bp_w[1];
    @(posedge clk) #1;
    data = bp_w[2];
    @(negedge clk);
    check("bp_ready_low", 64'(data_ready), 64'd0);
    check("bp_out_word0", 64'(enc_codeword), 64'(model_cw(bp_w[0], 1'b0)));
    @(posedge clk) #1;
    @(negedge clk);
    check("bp_ready_still_low", 64'(data_ready), 64'd0);
    check("bp_out_word0_held", 64'(enc_codeword), 64'(model_cw(bp_w[0], 1'b0)));
    @(posedge clk) #1;
    enc_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_low_while_draining", 64'(data_ready), 64'd0);
    @(posedge clk) #1;
    @(negedge clk);
    check("bp_ready_back", 64'(data_ready), 64'd1);
    check("bp_out_word1", 64'(enc_codeword), 64'(model_cw(bp_w[1], 1'b0)));
    @(posedge clk) #1;
    data_valid = 1'b0;
    @(negedge clk);
    check("bp_out_word2", 64'(enc_codeword), 64'(model_cw(bp_w[2], 1'b0)));
    repeat (2) @(negedge clk);
    check("bp_idle_after", 64'(enc_valid), 64'd0);
    check("bp_sb_drained", 64'(sb_even.size()), 64'd0);

    // Reset mid-transfer with OUT and SKID both occupied.
    @(posedge clk) #1;
    enc_ready  = 1'b0;
    data       = 48'h0F0F_0F0F_0F0F;
    data_valid = 1'b1;
    @(posedge clk) #1;
    data = 48'h1234_0000_0001;
    @(posedge clk) #1;
    data_valid = 1'b0;
    check("pre_reset_skid_full", 64'(data_ready), 64'd0);
    #2 rst = 1'b0;
    #1;
    check("midrst_enc_valid", 64'(enc_valid), 64'd0);
    check("midrst_enc_codeword", 64'(enc_codeword), 64'd0);
    check("midrst_data_ready", 64'(data_ready), 64'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    enc_ready = 1'b1;
    @(negedge clk);
    check("postrst_ready", 64'(data_ready), 64'd1);
    check("postrst_words_dropped", 64'(enc_valid), 64'd0);

    // Recovery: one word after the mid-transfer reset.
    @(posedge clk) #1;
    data       = 48'h0000_0000_0007;
    data_valid = 1'b1;
    @(posedge clk) #1;
    data_valid = 1'b0;
    @(negedge clk);
    check("recover_valid", 64'(enc_valid), 64'd1);
    check("recover_cw", 64'(enc_codeword), 64'h1_0000_0000_0007);
    repeat (2) @(negedge clk);
    check("final_sb_empty", 64'(sb_even.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
